matrix_op_initiator: RTL and testbench
======================================

// Module: matrix_op_initiator
// PURPOSE
//  Initiator side of the start/busy/done handshake used by the matrix arithmetic units.
//  Accepts one command from the EKF sequencer (valid/ready), pulses start to one unit,
//  waits for done with a timeout watchdog, and captures the ROWS x COLS result.
//  Returns result, error flag and measured latency (valid/ready).
//  One instance sits in front of each matrix unit (subtract, add, multiply) in the EKF datapath.
// PARAMETERS
//  ROWS            4     result matrix rows
//  COLS            4     result matrix columns
//  TIMEOUT_CYCLES  64    max WAIT cycles before error; >=1; DATA_WIDTH comes from fp_arith_pkg
// PORTS
//  clk          in   1                    clock, rising edge
//  rst_n        in   1                    async active-low reset
//  cmd_valid    in   1                    sequencer requests one operation
//  cmd_ready    out  1                    high only in IDLE
//  unit_start   out  1                    one-cycle start pulse to the unit
//  unit_busy    in   1                    unit busy flag
//  unit_done    in   1                    unit completion pulse (1 cycle)
//  unit_result  in   DATA_WIDTH[R][C]     unit output matrix, signed
//  resp_valid   out  1                    response available
//  resp_ready   in   1                    sequencer consumes response
//  resp_error   out  1                    1 = timed out, result_out not updated
//  result_out   out  DATA_WIDTH[R][C]     captured result, signed
//  lat_cycles   out  $clog2(TIMEOUT_CYCLES+1)  WAIT cycles of last op
//  spurious     out  1                    sticky: unit_done seen outside WAIT
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cmd_ready=0 during reset, unit_start=0,
//   resp_valid=0, resp_error=0, result_out=FP_ZERO all elements, lat_cycles=0, spurious=0,
//   timer=0. Mid-operation reset abandons the op; no response is issued.
//  All outputs are registered except cmd_ready (= state==IDLE).
//  IDLE:   cmd_valid && cmd_ready -> LAUNCH.
//  LAUNCH: if !unit_busy: unit_start=1 for exactly this cycle, timer<=0 -> WAIT.
//          If unit_busy: hold, unit_start=0, retry next cycle.
//  WAIT:   timer increments each cycle. unit_done=1 -> result_out<=unit_result (all
//          elements, same edge), resp_error<=0, lat_cycles<=timer+1 -> RESP.
//          No done and timer+1==TIMEOUT_CYCLES -> resp_error<=1, lat_cycles<=TIMEOUT_CYCLES,
//          result_out held -> RESP. Done on the timeout cycle wins (success).
//  RESP:   resp_valid=1, data stable until resp_valid && resp_ready; then resp_valid<=0 -> IDLE.
//          cmd_ready stays low in RESP, so there is at most one op in flight.
//  Latency: start at cycle S, done at S+D -> lat_cycles=D and resp_valid at S+D+1.
//   Accept-to-start is 1 cycle when the unit is idle.
//  unit_done while IDLE, LAUNCH or RESP: ignored for data; spurious<=1 (cleared only by reset).
//  Late done after a timeout: lands in RESP or IDLE and sets spurious.
//  Timer saturates and never wraps. Results pass through unmodified; no arithmetic.
// TESTING
//  1. Responder model, done D=18 after start, result A[i][j]=i*4+j: cmd -> 1 start pulse,
//     resp_valid at S+19, result_out==A, lat_cycles=18, resp_error=0.
//  2. unit_busy high 5 cycles after accept -> unit_start only after busy drops, exactly once.
//  3. No done, TIMEOUT_CYCLES=64 -> resp_error=1, lat_cycles=64, result_out unchanged.
//     Done at WAIT cycle 64 -> success, lat=64.
//  4. resp_ready low 10 cycles -> resp_valid and result_out stable; cmd_ready=0 throughout;
//     second cmd accepted only after handshake.
//  5. done pulse in IDLE -> spurious=1, no response. rst_n low in WAIT -> all outputs at
//     reset values asynchronously.
//  6. Back-to-back cmds with resp_ready=1: two starts, two responses in order with correct data.

Source files
------------

// File: rtl/matrix_op_initiator.sv
// Initiator for the start/busy/done handshake of a matrix arithmetic unit:
// takes one command, launches the unit, watches for done or timeout, returns the result.
package fp_arith_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] FP_ZERO = '0;
endpackage

module matrix_op_initiator
  import fp_arith_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int LW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             cmd_valid,
  output logic                                             cmd_ready,
  output logic                                             unit_start,
  input  logic                                             unit_busy,
  input  logic                                             unit_done,
  input  logic signed [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] unit_result,
  output logic                                             resp_valid,
  input  logic                                             resp_ready,
  output logic                                             resp_error,
  output logic signed [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] result_out,
  output logic [LW-1:0]                                    lat_cycles,
  output logic                                             spurious
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t        state;
  logic [LW-1:0] timer;
  logic [LW-1:0] timer_nxt;

  assign timer_nxt = timer + LW'(1);
  // Held low while reset is asserted even though the state already reads IDLE.
  assign cmd_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      unit_start <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      result_out <= {(ROWS*COLS){FP_ZERO}};
      lat_cycles <= '0;
      spurious   <= 1'b0;
      timer      <= '0;
    end else begin
      if (unit_done && state != WAIT) spurious <= 1'b1;
      case (state)
        IDLE: begin
          // Start is registered so it is high for the whole LAUNCH cycle when the unit is free.
          if (cmd_valid) begin
            unit_start <= !unit_busy;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (unit_start) begin
            unit_start <= 1'b0;
            timer      <= '0;
            state      <= WAIT;
          end else if (!unit_busy) begin
            unit_start <= 1'b1;
          end
        end
        WAIT: begin
          if (timer != LW'(TIMEOUT_CYCLES)) timer <= timer_nxt;
          // Done on the final allowed cycle takes priority over the timeout.
          if (unit_done) begin
            result_out <= unit_result;
            resp_error <= 1'b0;
            lat_cycles <= timer_nxt;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timer_nxt == LW'(TIMEOUT_CYCLES)) begin
            resp_error <= 1'b1;
            lat_cycles <= LW'(TIMEOUT_CYCLES);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_initiator.sv
// Randomized bench for matrix_op_initiator against a transaction-level model
// of latency, timeout and result capture.
module tb_matrix_op_initiator;
  import fp_arith_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int TO   = 64;
  localparam int DW   = DATA_WIDTH;
  localparam int LW   = $clog2(TO + 1);
  localparam int RW   = ROWS * COLS * DW;

  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] mat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, unit_start, unit_busy, unit_done;
  logic resp_valid, resp_ready, resp_error, spurious;
  logic signed [ROWS-1:0][COLS-1:0][DW-1:0] unit_result, result_out;
  logic [LW-1:0] lat_cycles;

  matrix_op_initiator #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .unit_start(unit_start), .unit_busy(unit_busy), .unit_done(unit_done),
    .unit_result(unit_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_error(resp_error), .result_out(result_out), .lat_cycles(lat_cycles),
    .spurious(spurious)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  mat_t model_res;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) m[i][j] = DW'($urandom);
    return m;
  endfunction

  // One command: unit busy for busy_n cycles from accept, done d cycles after start
  // (d > TO means never), then resp_ready withheld for rdy_n cycles.
  task automatic run_op(input int d, input int busy_n, input int rdy_n, input mat_t mat);
    int   s = -1, starts = 0, rv = -1;
    bit   exp_err = (d > TO);
    int   exp_lat = exp_err ? TO : d;
    mat_t exp_res = exp_err ? model_res : mat;
    @(negedge clk);
    chk("cmd_ready_idle", RW'(cmd_ready), RW'(1));
    cmd_valid = 1'b1;
    unit_busy = (busy_n > 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c < 400 && rv < 0; c++) begin
      unit_busy   = (c < busy_n);
      unit_done   = (s >= 0 && c == s + d);
      unit_result = unit_done ? mat : rand_mat();
      @(negedge clk);
      if (unit_start) begin starts++; if (s < 0) s = c; end
      if (resp_valid) rv = c;
      if (rv < 0) chk("cmd_ready_busy", RW'(cmd_ready), RW'(0));
      @(posedge clk); #1;
    end
    unit_done = 1'b0;
    unit_busy = 1'b0;
    chk("start_count", RW'(starts), RW'(1));
    chk("start_cycle", RW'(s), RW'(busy_n + 1));
    chk("resp_cycle", RW'(rv), RW'(s + exp_lat + 1));
    chk("resp_error", RW'(resp_error), RW'(exp_err));
    chk("lat_cycles", RW'(lat_cycles), RW'(exp_lat));
    chk("result", RW'(result_out), RW'(exp_res));
    for (int k = 0; k < rdy_n; k++) begin
      @(negedge clk);
      chk("hold_valid", RW'(resp_valid), RW'(1));
      chk("hold_result", RW'(result_out), RW'(exp_res));
      chk("hold_cmd_ready", RW'(cmd_ready), RW'(0));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("valid_dropped", RW'(resp_valid), RW'(0));
    model_res = exp_res;
  endtask

  initial begin
    mat_t a;
    rst_n = 1'b0; cmd_valid = 1'b0; unit_busy = 1'b0; unit_done = 1'b0;
    resp_ready = 1'b0; unit_result = '0; model_res = '0;
    #3;
    chk("rst_cmd_ready", RW'(cmd_ready), RW'(0));
    chk("rst_start", RW'(unit_start), RW'(0));
    chk("rst_valid", RW'(resp_valid), RW'(0));
    chk("rst_result", RW'(result_out), RW'(0));
    chk("rst_lat", RW'(lat_cycles), RW'(0));
    chk("rst_spurious", RW'(spurious), RW'(0));
    #20 rst_n = 1'b1;

    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) a[i][j] = DW'(i * COLS + j);
    run_op(18, 0, 0, a);
    run_op(7, 5, 0, rand_mat());
    run_op(1000, 0, 0, rand_mat());
    run_op(TO, 0, 0, rand_mat());
    run_op(TO + 1, 2, 0, rand_mat());
    run_op(1, 0, 10, rand_mat());
    run_op(3, 0, 0, rand_mat());
    run_op(5, 0, 0, rand_mat());
    for (int n = 0; n < 25; n++)
      run_op(($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(1, TO + 4)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), rand_mat());

    // Done pulse while idle: sticky flag, no response.
    @(posedge clk); #1 unit_done = 1'b1;
    @(posedge clk); #1 unit_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_no_resp", RW'(resp_valid), RW'(0));
    end
    chk("spurious_set", RW'(spurious), RW'(1));

    // Reset asserted mid-WAIT, away from a clock edge.
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("wrst_cmd_ready", RW'(cmd_ready), RW'(0));
    chk("wrst_start", RW'(unit_start), RW'(0));
    chk("wrst_valid", RW'(resp_valid), RW'(0));
    chk("wrst_error", RW'(resp_error), RW'(0));
    chk("wrst_result", RW'(result_out), RW'(0));
    chk("wrst_lat", RW'(lat_cycles), RW'(0));
    chk("wrst_spurious", RW'(spurious), RW'(0));
    #20 rst_n = 1'b1;
    model_res = '0;
    repeat (TO + 5) begin
      @(negedge clk);
      if (resp_valid) chk("abandoned_resp", RW'(resp_valid), RW'(0));
    end
    chk("post_rst_cmd_ready", RW'(cmd_ready), RW'(1));
    run_op(9, 1, 2, rand_mat());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
